// File: rtl/io_uart_pkg.sv
// Shared UART constants and transmit state encodings for the IO block.
package io_uart_pkg;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;
    localparam int   UART_STOP_BITS  = 1;

    localparam logic [2:0] TX_IDLE   = 3'd0;
    localparam logic [2:0] TX_POP    = 3'd1;
    localparam logic [2:0] TX_LOAD   = 3'd2;
    localparam logic [2:0] TX_START  = 3'd3;
    localparam logic [2:0] TX_DATA   = 3'd4;
    localparam logic [2:0] TX_STOP   = 3'd5;
    localparam logic [2:0] TX_PARITY = 3'd6;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    assign bit_tick = (count == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clear || bit_tick)
            count <= '0;
        else
            count <= count + 1'b1;
    end

endmodule

// File: rtl/uart_fifo_tx.sv
// FIFO-drain UART transmitter: pops words and sends them LSB byte first as 8N1 frames.
// Defining UART_TX_PARITY_EN inserts an even parity bit per frame (8E1).
module uart_fifo_tx
    import io_uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_pop,
    output logic                  tx,
    output logic                  busy,
    output logic                  word_done
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);
    localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);

    logic [2:0]            state;
    logic [2:0]            bit_cnt;
    logic [IDX_W-1:0]      byte_idx;
    logic [DATA_WIDTH-1:0] shift;
    logic                  bit_tick;
    logic                  clear;
`ifdef UART_TX_PARITY_EN
    logic                  parity;
`endif

    // Untimed states hold the divider at zero so every timed state starts a full bit.
    assign clear = (state == TX_IDLE) || (state == TX_POP) || (state == TX_LOAD);

    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .bit_tick (bit_tick)
    );

    // The word register shifts right one bit per data bit, so the current byte is always at bit 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= TX_IDLE;
            bit_cnt   <= '0;
            byte_idx  <= '0;
            shift     <= '0;
            tx        <= UART_IDLE_LEVEL;
            fifo_pop  <= 1'b0;
            busy      <= 1'b0;
            word_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity    <= 1'b0;
`endif
        end else begin
            fifo_pop  <= 1'b0;
            word_done <= 1'b0;
            case (state)
                TX_IDLE: begin
                    tx <= UART_IDLE_LEVEL;
                    if (enable && !fifo_empty) begin
                        fifo_pop <= 1'b1;
                        busy     <= 1'b1;
                        state    <= TX_POP;
                    end
                end
                TX_POP: state <= TX_LOAD;
                TX_LOAD: begin
                    shift    <= fifo_data;
                    byte_idx <= '0;
                    tx       <= 1'b0;
                    state    <= TX_START;
                end
                TX_START: if (bit_tick) begin
                    tx      <= shift[0];
                    shift   <= shift >> 1;
                    bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                    parity  <= shift[0];
`endif
                    state   <= TX_DATA;
                end
                TX_DATA: if (bit_tick) begin
                    if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        tx    <= parity;
                        state <= TX_PARITY;
`else
                        tx    <= UART_IDLE_LEVEL;
                        state <= TX_STOP;
`endif
                    end else begin
                        tx      <= shift[0];
                        shift   <= shift >> 1;
                        bit_cnt <= bit_cnt + 1'b1;
`ifdef UART_TX_PARITY_EN
                        parity  <= parity ^ shift[0];
`endif
                    end
                end
`ifdef UART_TX_PARITY_EN
                TX_PARITY: if (bit_tick) begin
                    tx    <= UART_IDLE_LEVEL;
                    state <= TX_STOP;
                end
`endif
                TX_STOP: if (bit_tick) begin
                    if (byte_idx == LAST_IDX) begin
                        word_done <= 1'b1;
                        busy      <= 1'b0;
                        tx        <= UART_IDLE_LEVEL;
                        state     <= TX_IDLE;
                    end else begin
                        byte_idx <= byte_idx + 1'b1;
                        tx       <= 1'b0;
                        state    <= TX_START;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    tx    <= UART_IDLE_LEVEL;
                    state <= TX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Directed scoreboard bench for uart_fifo_tx with a FIFO model and a serial-line decoder.
module tb_uart_fifo_tx;

    localparam int DW    = 32;
    localparam int CPB   = 4;
    localparam int BYTES = DW / 8;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int WORD_CYCLES = BYTES * FRAME_BITS * CPB;

    logic          clk        = 1'b0;
    logic          reset      = 1'b1;
    logic          enable     = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_data  = '0;
    logic          fifo_pop;
    logic          tx;
    logic          busy;
    logic          word_done;

    int          vectors     = 0;
    int          miscompares = 0;
    int unsigned cyc         = 0;
    int unsigned pops        = 0;
    bit          mon_skip    = 1'b0;

    logic [31:0] fifo_q[$];
    logic [7:0]  exp_bytes[$];

    uart_fifo_tx #(
        .DATA_WIDTH   (DW),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_pop   (fifo_pop),
        .tx         (tx),
        .busy       (busy),
        .word_done  (word_done)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        fifo_q.push_back(w);
        for (int i = 0; i < BYTES; i++) exp_bytes.push_back(w[8*i +: 8]);
    endtask

    task automatic wait_pop(output int unsigned c);
        int n;
        n = 0;
        while (fifo_pop !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        c = cyc;
        check("pop_seen", {31'b0, fifo_pop}, 32'd1);
    endtask

    task automatic wait_done(output int unsigned c, output int unsigned busy_low);
        int n;
        n = 0;
        busy_low = 0;
        while (word_done !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
            if (word_done !== 1'b1 && busy !== 1'b1) busy_low++;
        end
        c = cyc;
        check("word_done_seen", {31'b0, word_done}, 32'd1);
    endtask

    // FIFO model: registered read data appears in the cycle after the pop strobe.
    initial forever begin
        @(negedge clk);
        if (fifo_pop === 1'b1) begin
            pops++;
            check("pop_when_nonempty", {31'b0, fifo_q.size() != 0}, 32'd1);
            if (fifo_q.size() != 0) fifo_data = fifo_q.pop_front();
        end
        fifo_empty = (fifo_q.size() == 0);
    end

    // Serial decoder: samples each bit near its middle and scores it against the expected bytes.
    initial begin
        logic [7:0] b;
        logic       prev, start_ok, stop_bit, par;
        prev = 1'b1;
        par  = 1'b0;
        forever begin
            @(negedge clk);
            if (prev === 1'b1 && tx === 1'b0) begin
                repeat (2) @(negedge clk);
                start_ok = (tx === 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
`ifdef UART_TX_PARITY_EN
                repeat (CPB) @(negedge clk);
                par = tx;
`endif
                repeat (CPB) @(negedge clk);
                stop_bit = tx;
                if (!mon_skip) begin
                    check("start_bit", {31'b0, start_ok}, 32'd1);
                    check("stop_bit", {31'b0, stop_bit}, 32'd1);
                    check("byte_expected", {31'b0, exp_bytes.size() != 0}, 32'd1);
                    if (exp_bytes.size() != 0) begin
                        logic [7:0] e;
                        e = exp_bytes.pop_front();
                        check("byte_value", {24'b0, b}, {24'b0, e});
`ifdef UART_TX_PARITY_EN
                        check("parity_bit", {31'b0, par}, {31'b0, ^e});
`endif
                    end
                end
                prev = stop_bit;
            end else begin
                prev = tx;
            end
        end
    end

    initial begin
        int unsigned c_pop, c_done, busy_low, tx_low, p0, gap;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_tx", {31'b0, tx}, 32'd1);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_pop", {31'b0, fifo_pop}, 32'd0);
        check("reset_word_done", {31'b0, word_done}, 32'd0);
        reset = 1'b0;

        // Single word
        push_word(32'hA5C30F81);
        enable = 1'b1;
        wait_pop(c_pop);
        wait_done(c_done, busy_low);
        check("single_done_latency", c_done - c_pop, 32'(2 + WORD_CYCLES));
        check("single_busy_low", busy_low, 32'd0);
        check("single_busy_after", {31'b0, busy}, 32'd0);
        repeat (10) @(negedge clk);
        check("single_pops", pops, 32'd1);
        check("single_bytes_left", exp_bytes.size(), 32'd0);

        // Empty / enable gating
        p0 = pops;
        tx_low = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1) tx_low++;
        end
        check("empty_no_pop", pops, p0);
        check("empty_tx_idle", tx_low, 32'd0);
        enable = 1'b0;
        push_word(32'h00000001);
        push_word(32'hFFFFFFFF);
        repeat (50) @(negedge clk);
        check("disabled_no_pop", pops, p0);
        check("disabled_busy", {31'b0, busy}, 32'd0);

        // Back-to-back words
        enable = 1'b1;
        wait_pop(c_pop);
        wait_done(c_done, busy_low);
        gap = 0;
        for (int n = 0; n < 20; n++) begin
            if (tx !== 1'b1) break;
            gap++;
            @(negedge clk);
        end
        check("b2b_gap", gap, 32'd3);
        wait_done(c_done, busy_low);
        repeat (10) @(negedge clk);
        check("b2b_pops", pops, p0 + 2);
        check("b2b_bytes_left", exp_bytes.size(), 32'd0);

        // Enable dropped during byte 1
        p0 = pops;
        push_word(32'h12345678);
        fifo_q.push_back(32'h0BADF00D);
        wait_pop(c_pop);
        repeat (2 + FRAME_BITS * CPB + 10) @(negedge clk);
        enable = 1'b0;
        wait_done(c_done, busy_low);
        check("drop_done_latency", c_done - c_pop, 32'(2 + WORD_CYCLES));
        repeat (60) @(negedge clk);
        check("drop_pops", pops, p0 + 1);
        check("drop_bytes_left", exp_bytes.size(), 32'd0);
        check("drop_word_held", fifo_q.size(), 32'd1);
        fifo_q.delete();
        repeat (2) @(negedge clk);

        // Parity pattern word (bytes 07,03,00,00 -> even parity 1,0,0,0)
        p0 = pops;
        push_word(32'h00000307);
        enable = 1'b1;
        wait_pop(c_pop);
        wait_done(c_done, busy_low);
        check("parity_word_latency", c_done - c_pop, 32'(2 + WORD_CYCLES));
        repeat (10) @(negedge clk);
        check("parity_word_pops", pops, p0 + 1);
        check("parity_bytes_left", exp_bytes.size(), 32'd0);

        // Reset in the middle of DATA
        fifo_q.push_back(32'hDEADBE00);
        wait_pop(c_pop);
        repeat (2 + CPB + 2) @(negedge clk);
        check("mid_data_tx_low", {31'b0, tx}, 32'd0);
        check("mid_data_busy", {31'b0, busy}, 32'd1);
        mon_skip = 1'b1;
        #2 reset = 1'b1;
        #1;
        check("async_reset_tx", {31'b0, tx}, 32'd1);
        check("async_reset_busy", {31'b0, busy}, 32'd0);
        check("async_reset_pop", {31'b0, fifo_pop}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        p0 = pops;
        tx_low = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx !== 1'b1) tx_low++;
        end
        mon_skip = 1'b0;
        check("post_reset_no_pop", pops, p0);
        check("post_reset_tx_idle", tx_low, 32'd0);
        check("post_reset_busy", {31'b0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
